// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: default parameters and counter-width helper for the switch debouncer.
package sw_debounce_pkg;
  localparam int DEF_NUM_CH       = 16;
  localparam int DEF_TICK_DIV     = 10000;
  localparam int DEF_STABLE_TICKS = 4;
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction
endpackage

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: one switch channel, synchronizer plus tick-qualified stable level.
// Edge registers exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw,
`ifdef SW_DEBOUNCE_EDGE_EN
  output logic stab,
  output logic rise,
  output logic fall
`else
  output logic stab
`endif
);
  localparam int CW = cnt_width(STABLE_TICKS);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stab   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw};
      if (tick) begin
        if (sync_q[1] == stab) cnt <= '0;
        else if (cnt == CW'(STABLE_TICKS - 1)) begin
          stab <= sync_q[1];
          cnt  <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
`ifdef SW_DEBOUNCE_EDGE_EN
  // stab_d lags stab by one cycle so the pulses land the cycle after the change
  logic stab_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stab_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      stab_d <= stab;
      rise   <= stab & ~stab_d;
      fall   <= ~stab & stab_d;
    end
`endif
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: multi-channel switch debouncer with a shared sample-tick prescaler.
// rise_o/fall_o exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] sw_i,
  output logic [NUM_CH-1:0] sw_o,
`ifdef SW_DEBOUNCE_EDGE_EN
  output logic              tick_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o
`else
  output logic              tick_o
`endif
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] pre;
  assign tick_o = en_i && (pre == PW'(TICK_DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else if (en_i) pre <= tick_o ? '0 : pre + 1'b1;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sw_debounce_ch #(.STABLE_TICKS(STABLE_TICKS)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick_o),
      .sw   (sw_i[i]),
`ifdef SW_DEBOUNCE_EDGE_EN
      .stab (sw_o[i]),
      .rise (rise_o[i]),
      .fall (fall_o[i])
`else
      .stab (sw_o[i])
`endif
    );
  end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed and random stimulus against a sample-history model of the debouncer.
module tb_sw_debounce;
  localparam int N = 16;
  logic clk = 1'b0, rst_n = 1'b0, en_i = 1'b1, tick_o;
  logic [N-1:0] sw_i = '0, sw_o, rise_o, fall_o;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sw_debounce #(.NUM_CH(N), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .sw_i(sw_i), .sw_o(sw_o),
`ifdef SW_DEBOUNCE_EDGE_EN
    .tick_o(tick_o), .rise_o(rise_o), .fall_o(fall_o)
`else
    .tick_o(tick_o)
`endif
  );
`ifndef SW_DEBOUNCE_EDGE_EN
  assign rise_o = '0;
  assign fall_o = '0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the level flips once the last 3 tick samples (since reset) all disagree with it.
  logic [N-1:0] m_stab, s1, s2, h0, h1, h2, m_up, m_dn, m_rise, m_fall, flip;
  int n_samp, phase;
  initial forever begin
    if (!rst_n) begin
      m_stab = '0; s1 = '0; s2 = '0; h0 = '0; h1 = '0; h2 = '0;
      m_up = '0; m_dn = '0; m_rise = '0; m_fall = '0; n_samp = 0; phase = 0;
    end else begin
      m_rise = m_up; m_fall = m_dn; m_up = '0; m_dn = '0;
      if (en_i && phase == 3) begin
        h2 = h1; h1 = h0; h0 = s2;
        if (n_samp < 3) n_samp++;
        flip = (n_samp >= 3) ? (~(h0 ^ h1) & ~(h1 ^ h2) & (h0 ^ m_stab)) : '0;
        m_up = flip & h0; m_dn = flip & ~h0; m_stab = m_stab ^ flip;
      end
      s2 = s1; s1 = sw_i;
      if (en_i) phase = (phase + 1) % 4;
    end
    @(posedge clk or negedge rst_n);
  end

  always @(negedge clk) begin
    chk("sw_o", 32'(sw_o), 32'(m_stab));
    chk("tick_o", 32'(tick_o), 32'(rst_n && en_i && phase == 3));
`ifdef SW_DEBOUNCE_EDGE_EN
    chk("rise_o", 32'(rise_o), 32'(m_rise));
    chk("fall_o", 32'(fall_o), 32'(m_fall));
`endif
  end

  task automatic step(input int c);
    repeat (c) @(negedge clk);
    #1;
  endtask

  task automatic edges_to_sw0(output int e);
    e = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (sw_o[0]) begin e = k; break; end
    end
  endtask

  int t, e;
  initial begin
    step(3);
    chk("reset sw_o", 32'(sw_o), 0);
    chk("reset tick_o", 32'(tick_o), 0);
    chk("reset edges", 32'(rise_o | fall_o), 0);
    rst_n = 1'b1;
    t = 0;
    repeat (16) begin @(negedge clk); if (tick_o) t++; end
    chk("ticks in 16 cycles", t, 4);
    chk("idle sw_o", 32'(sw_o), 0);
    #1;
    sw_i[0] = 1'b1;
    t = 0;
    for (int k = 0; k < 40 && !sw_o[0]; k++) step(1);
    chk("sw0 qualifies", 32'(sw_o[0]), 1);
`ifdef SW_DEBOUNCE_EDGE_EN
    t = 0;
    repeat (6) begin @(negedge clk); if (rise_o[0]) t++; end
    chk("rise0 width", t, 1);
    #1;
`endif
    sw_i[3] = 1'b1; step(8); sw_i[3] = 1'b0; step(20);
    chk("glitch sw3", 32'(sw_o[3]), 0);
    sw_i = '0;
    for (int k = 0; k < 40 && sw_o != '0; k++) step(1);
    chk("all clear", 32'(sw_o), 0);
    sw_i = '1;
    for (int k = 0; k < 40 && sw_o == '0; k++) step(1);
    chk("all rise together", 32'(sw_o), 32'hFFFF);
    step(1);
    sw_i = '0; step(6);
    en_i = 1'b0; step(20);
    chk("frozen sw_o", 32'(sw_o), 32'hFFFF);
    en_i = 1'b1;
    for (int k = 0; k < 40 && sw_o != '0; k++) step(1);
    chk("resume clear", 32'(sw_o), 0);
    rst_n = 1'b0; sw_i = 16'h0001; step(2);
    rst_n = 1'b1;
    edges_to_sw0(e);
    chk("latency from reset", e, 12);
    rst_n = 1'b0; step(2);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("reset mid-qual sw_o", 32'(sw_o), 0);
    chk("reset mid-qual tick", 32'(tick_o), 0);
    step(1);
    rst_n = 1'b1;
    edges_to_sw0(e);
    chk("requalify after reset", e, 12);
    for (int c = 0; c < 2500; c++) begin
      step(1);
      for (int b = 0; b < N; b++) if ($urandom_range(31) == 0) sw_i[b] = ~sw_i[b];
      en_i = ($urandom_range(9) != 0);
      if (c == 1200) rst_n = 1'b0;
      if (c == 1203) rst_n = 1'b1;
    end
    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
